// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the fetch-side memory responder: FSM state encodings,
// address width, RVC detection and memory-arbiter client ids.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W = 32;

    // Fetch FSM state encodings
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StRead = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    // Memory arbiter client ids
    localparam logic [1:0] ArbIfetch = 2'd0;
    localparam logic [1:0] ArbLoad   = 2'd1;
    localparam logic [1:0] ArbStore  = 2'd2;

    // Compressed instructions are those whose two low opcode bits are not 2'b11.
    function automatic logic is_rvc(input logic [7:0] lo_byte);
        return lo_byte[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped instruction cache storage: valid/tag/data per entry,
// one combinational read port and one synchronous write port.
module icache_array #(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned IDX_W   = $clog2(ENTRIES),
    parameter int unsigned TAG_W   = 32 - IDX_W - 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic [31:0]      rd_data,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_data
);

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q  [ENTRIES];
    logic [31:0]        data_q [ENTRIES];

    // Valid bits: cleared only by reset, set on fill
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, no reset needed behind the valid bits
    always_ff @(posedge clk_in) begin
        if (we) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign rd_data = data_q[rd_idx];

endmodule

// File: rtl/inst_mem_responder.sv
// Instruction-fetch memory responder: reads one instruction byte-serially from
// the shared byte-wide RAM via the arbiter, stopping after two bytes for RVC.
// Optional direct-mapped instruction cache enabled by defining ICACHE_EN.
module inst_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ICACHE_ENTRIES = 64
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        _clear,
    input  logic        _InstFetcher_need_inst,
    input  logic [31:0] _next_pc,
    output logic        _inst_ready,
    output logic [31:0] _inst_out,
    output logic        _mem_busy,
    output logic        _mem_req,
    input  logic        _mem_gnt,
    output logic [31:0] _mem_a,
    input  logic [7:0]  _mem_din
);

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] data_q, data_d;
    logic        cache_hit;
    logic [31:0] cache_rdata;
    logic        cache_we;

`ifdef ICACHE_EN
    localparam int unsigned IdxW = $clog2(ICACHE_ENTRIES);

    icache_array #(
        .ENTRIES(ICACHE_ENTRIES)
    ) u_icache (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rd_idx (_next_pc[IdxW:1]),
        .rd_tag (_next_pc[ADDR_W-1:IdxW+1]),
        .hit    (cache_hit),
        .rd_data(cache_rdata),
        .we     (cache_we && rdy_in),
        .wr_idx (pc_q[IdxW:1]),
        .wr_tag (pc_q[ADDR_W-1:IdxW+1]),
        .wr_data(data_d)
    );
`else
    logic unused_cache;
    assign cache_hit    = 1'b0;
    assign cache_rdata  = '0;
    assign unused_cache = cache_we ^ (ICACHE_ENTRIES != 0);
`endif

    // Next-state: fetch sequencing; cnt counts READ cycles, byte k lands at cnt == k+1
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        cache_we = 1'b0;
        if (_clear) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (_InstFetcher_need_inst) begin
                        pc_d = _next_pc;
                        if (cache_hit) begin
                            data_d  = cache_rdata;
                            state_d = StDone;
                        end else begin
                            state_d = StReq;
                        end
                    end
                end
                StReq: begin
                    if (_mem_gnt) begin
                        state_d = StRead;
                        cnt_d   = 3'd0;
                    end
                end
                StRead: begin
                    cnt_d = cnt_q + 3'd1;
                    case (cnt_q)
                        3'd1:    data_d[7:0]   = _mem_din;
                        3'd2:    data_d[15:8]  = _mem_din;
                        3'd3:    data_d[23:16] = _mem_din;
                        3'd4:    data_d[31:24] = _mem_din;
                        default: ;
                    endcase
                    // Byte0 is already in data_q when byte1 arrives
                    if (cnt_q == 3'd2 && is_rvc(data_q[7:0])) begin
                        data_d[31:16] = 16'h0000;
                        state_d       = StDone;
                        cache_we      = 1'b1;
                    end else if (cnt_q == 3'd4) begin
                        state_d  = StDone;
                        cache_we = 1'b1;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // State registers; rdy_in low freezes everything
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= StIdle;
            pc_q    <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    // Address only driven for the four possible byte slots of a fetch
    assign _mem_a      = (state_q == StRead && cnt_q < 3'd4) ? pc_q + {29'd0, cnt_q} : '0;
    assign _mem_req    = (state_q == StReq || state_q == StRead) && !_clear;
    assign _mem_busy   = state_q != StIdle;
    assign _inst_ready = (state_q == StDone) && !_clear;
    assign _inst_out   = data_q;

endmodule
